// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer, Gray publish and full/almost_full flags for async FIFOs.
// Optional sticky overflow flag: define FIFO_WPTR_OVERFLOW_FLAG_EN.
module fifo_wptr_full_ctrl #(
  parameter int PTR      = 8,
  parameter int AFULL_TH = (1 << PTR) - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [PTR:0]   rd_gray_ptr_async,
`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
  input  logic           ovf_clr,
  output logic           overflow,
`endif
  output logic           wr_ack,
  output logic [PTR-1:0] wr_addr,
  output logic [PTR:0]   wr_gray_ptr,
  output logic           full,
  output logic           almost_full
);

  localparam logic [PTR:0] LP_AFTH = (PTR+1)'(AFULL_TH);

  logic [PTR:0] r_wbin;
  logic [PTR:0] r_wgray;
  logic [PTR:0] r_rq1;
  logic [PTR:0] r_rq2;
  logic         r_full;
  logic         r_afull;

  logic         w_ack;
  logic [PTR:0] w_wbin_next;
  logic [PTR:0] w_wgray_next;
  logic [PTR:0] w_rbin;
  logic [PTR:0] w_fill_next;
  logic         w_full_next;
  logic         w_afull_next;

  assign w_ack        = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + (PTR+1)'(w_ack);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= PTR; i++) begin
      w_rbin[i] = ^(r_rq2 >> i);
    end
  end

  assign w_fill_next  = w_wbin_next - w_rbin;
  assign w_afull_next = (w_fill_next >= LP_AFTH);
  assign w_full_next  =
    (w_wgray_next == {~r_rq2[PTR:PTR-1], r_rq2[PTR-2:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq1   <= '0;
      r_rq2   <= '0;
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
    end else begin
      r_rq1   <= rd_gray_ptr_async;
      r_rq2   <= r_rq1;
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
    end
  end

`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
  logic r_ovf;

  // set beats clear when both happen on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (wr_en & r_full) | (r_ovf & ~ovf_clr);
    end
  end

  assign overflow = r_ovf;
`endif

  assign wr_ack      = w_ack;
  assign wr_addr     = r_wbin[PTR-1:0];
  assign wr_gray_ptr = r_wgray;
  assign full        = r_full;
  assign almost_full = r_afull;

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Directed bench for fifo_wptr_full_ctrl at PTR=3, AFULL_TH=6.
// Table vectors plus hand sequences for wrap, reset and overflow.
module tb_fifo_wptr_full_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_gray;
  logic       wr_ack;
  logic [2:0] wr_addr;
  logic [3:0] wr_gray_ptr;
  logic       full;
  logic       almost_full;
`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int n_chk;
  int n_fail;

  fifo_wptr_full_ctrl #(
    .PTR      (3),
    .AFULL_TH (6)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wr_en             (wr_en),
    .rd_gray_ptr_async (rd_gray),
`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
    .ovf_clr           (ovf_clr),
    .overflow          (overflow),
`endif
    .wr_ack            (wr_ack),
    .wr_addr           (wr_addr),
    .wr_gray_ptr       (wr_gray_ptr),
    .full              (full),
    .almost_full       (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] rd;
    logic       ack;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
  } vec_t;

  vec_t tv [14];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_gray = 4'b0000;
`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
    ovf_clr = 1'b0;
`endif

    //            we  rd       ack addr  gray     full af
    tv[0]  = '{1'b0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 4'b0000, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 4'b0000, 1'b1, 3'd1, 4'b0011, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 4'b0000, 1'b1, 3'd2, 4'b0010, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 4'b0000, 1'b1, 3'd3, 4'b0110, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 4'b0000, 1'b1, 3'd4, 4'b0111, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 4'b0000, 1'b1, 3'd5, 4'b0101, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 4'b0000, 1'b1, 3'd6, 4'b0100, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 4'b0000, 1'b1, 3'd7, 4'b1100, 1'b1, 1'b1};
    tv[9]  = '{1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1};
    tv[10] = '{1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1};
    tv[11] = '{1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1};
    tv[12] = '{1'b0, 4'b0001, 1'b0, 3'd0, 4'b1100, 1'b0, 1'b1};
    tv[13] = '{1'b1, 4'b0001, 1'b1, 3'd0, 4'b1101, 1'b1, 1'b1};

    #12;
    chk("rst_ack",   int'(wr_ack), 0);
    chk("rst_addr",  int'(wr_addr), 0);
    chk("rst_gray",  int'(wr_gray_ptr), 0);
    chk("rst_full",  int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
    chk("rst_ovf",   int'(overflow), 0);
`endif
    wr_en = 1'b1;
    #1;
    chk("rst_ack_follows", int'(wr_ack), 1);
    wr_en = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    foreach (tv[i]) begin
      wr_en   = tv[i].we;
      rd_gray = tv[i].rd;
      #1;
      chk($sformatf("v%0d_ack", i),  int'(wr_ack), int'(tv[i].ack));
      chk($sformatf("v%0d_addr", i), int'(wr_addr), int'(tv[i].addr));
      tick();
      chk($sformatf("v%0d_gray", i), int'(wr_gray_ptr), int'(tv[i].gray));
      chk($sformatf("v%0d_full", i), int'(full), int'(tv[i].full));
      chk($sformatf("v%0d_af", i),   int'(almost_full), int'(tv[i].af));
    end

`ifdef FIFO_WPTR_OVERFLOW_FLAG_EN
    wr_en = 1'b0;
    chk("ovf_sticky", int'(overflow), 1);
    wr_en   = 1'b1;
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", int'(overflow), 1);
    wr_en = 1'b0;
    tick();
    chk("ovf_cleared", int'(overflow), 0);
    ovf_clr = 1'b0;
`endif

    // wrap: read pointer trails writes so the FIFO never fills
    wr_en   = 1'b0;
    rd_gray = 4'b0000;
    rst_n   = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      wr_en   = 1'b1;
      rd_gray = g(4'(k));
      #1;
      chk($sformatf("wrap%0d_ack", k),  int'(wr_ack), 1);
      chk($sformatf("wrap%0d_addr", k), int'(wr_addr), k % 8);
      tick();
      chk($sformatf("wrap%0d_gray", k), int'(wr_gray_ptr),
          int'(g(4'(k + 1))));
      chk($sformatf("wrap%0d_full", k), int'(full), 0);
      chk($sformatf("wrap%0d_af", k), int'(almost_full), 0);
    end
    wr_en = 1'b0;
    chk("wrap_addr_end", int'(wr_addr), 0);

    // async reset while full
    rd_gray = 4'b0000;
    rst_n   = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1;
      tick();
    end
    chk("mid_full_pre", int'(full), 1);
    chk("mid_af_pre", int'(almost_full), 1);
    rst_n = 1'b0;
    wr_en = 1'b0;
    #1;
    chk("mid_ack",   int'(wr_ack), 0);
    chk("mid_addr",  int'(wr_addr), 0);
    chk("mid_gray",  int'(wr_gray_ptr), 0);
    chk("mid_full",  int'(full), 0);
    chk("mid_afull", int'(almost_full), 0);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    chk("post_ack",  int'(wr_ack), 1);
    chk("post_addr", int'(wr_addr), 0);
    tick();
    chk("post_gray", int'(wr_gray_ptr), 1);
    chk("post_full", int'(full), 0);
    wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
